// File: rtl/in_mux_ctrl.sv
// ---------------------------------------------------------------------------
// in_mux_ctrl -- tile sequencer in front of an in_mux.
//
// Pulls 32-bit activation words from a buffer. Each word is issued to the
// in_mux as N read beats. N depends on the weight bitwidth: 8b -> 4, 4b -> 2,
// 2b -> 1. After the last word it waits one cycle for the in_mux output
// register to drain, then pulses done.
//
// Optional feature: define IN_MUX_CTRL_STALL_CNT_EN to build a saturating
// counter of stalled issue cycles. Without the macro, stall_cnt is tied to 0.
//
// Handshake: a word transfers on a rising edge where word_valid and
// word_ready are both 1. word_ready is combinational. It is high in LOAD,
// and also on the final beat of a word that is not the last word, so the next
// word can be taken with no bubble.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   RST          in   asynchronous active-high reset
//   start        in   tile start request; only looked at in IDLE
//   cfg_bitwidth in   3  weight bitwidth one-hot: 001=2b, 010=4b, 100=8b
//   cfg_words    in   CNT_W  number of activation words in the tile
//   word_valid   in   activation buffer offers word_data
//   word_data    in   32 activation word
//   word_ready   out  controller takes the word this cycle
//   stall        in   array back-pressure; blocks issue
//   mux_rd_en    out  in_mux rd_en
//   mux_data     out  32 in_mux data_in (the held word)
//   mux_bitwidth out  3  in_mux weight_bitwidth (held for the whole tile)
//   arr_valid    out  in_mux data_out valid (mux_rd_en delayed one cycle)
//   busy         out  controller is not in IDLE
//   done         out  one-cycle tile completion pulse
//   cfg_err      out  sticky illegal-bitwidth flag; cleared by the next start
//   stall_cnt    out  16 stalled-issue cycle count (0 without the macro)
// ---------------------------------------------------------------------------
module in_mux_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             start,
   input  logic [2:0]       cfg_bitwidth,
   input  logic [CNT_W-1:0] cfg_words,
   input  logic             word_valid,
   input  logic [31:0]      word_data,
   output logic             word_ready,
   input  logic             stall,
   output logic             mux_rd_en,
   output logic [31:0]      mux_data,
   output logic [2:0]       mux_bitwidth,
   output logic             arr_valid,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [15:0]      stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q;
   logic [1:0]       phase_q;
   logic [CNT_W-1:0] left_q;
   logic [31:0]      data_q;
   logic [2:0]       bw_q;
   logic             cfg_err_q;
   logic             arr_valid_q;

   logic [1:0]       last_phase;
   logic             issue_go;
   logic             last_beat;
   logic             last_word;
   logic             word_hs;
   logic             bw_legal;
   logic             start_acc;

   // Index of the final beat of a word, taken from the latched bitwidth.
   always_comb begin
      last_phase = 2'd0;
      case (bw_q)
         3'b100:  last_phase = 2'd3;
         3'b010:  last_phase = 2'd1;
         default: last_phase = 2'd0;
      endcase
   end

   assign bw_legal  = (cfg_bitwidth == 3'b001) || (cfg_bitwidth == 3'b010) ||
                      (cfg_bitwidth == 3'b100);
   assign start_acc = (state_q == S_IDLE) && start;
   assign issue_go  = (state_q == S_ISSUE) && !stall;
   assign last_beat = issue_go && (phase_q == last_phase);
   assign last_word = (left_q == CNT_W'(1));

   // On the final beat of a word that is not the last word, also offer
   // word_ready so the next word can load with no bubble.
   assign word_ready = (state_q == S_LOAD) || (last_beat && !last_word);
   assign word_hs    = word_valid && word_ready;

   assign mux_rd_en    = issue_go;
   assign mux_data     = data_q;
   assign mux_bitwidth = bw_q;
   assign arr_valid    = arr_valid_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign cfg_err      = cfg_err_q;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         phase_q   <= 2'd0;
         left_q    <= '0;
         data_q    <= '0;
         bw_q      <= 3'b000;
         cfg_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  bw_q      <= cfg_bitwidth;
                  left_q    <= cfg_words;
                  phase_q   <= 2'd0;
                  cfg_err_q <= 1'b0;
                  if (!bw_legal) begin
                     cfg_err_q <= 1'b1;
                     state_q   <= S_DONE;
                  end else if (cfg_words == '0) begin
                     state_q   <= S_DONE;
                  end else begin
                     state_q   <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (word_hs) begin
                  data_q  <= word_data;
                  phase_q <= 2'd0;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // A stalled cycle holds phase and data_q.
               if (issue_go) begin
                  if (last_beat) begin
                     left_q  <= left_q - CNT_W'(1);
                     phase_q <= 2'd0;
                     if (last_word) begin
                        state_q <= S_DRAIN;
                     end else if (word_hs) begin
                        data_q  <= word_data;
                        state_q <= S_ISSUE;
                     end else begin
                        state_q <= S_LOAD;
                     end
                  end else begin
                     phase_q <= phase_q + 2'd1;
                  end
               end
            end
            S_DRAIN: state_q <= S_DONE;
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // arr_valid stands for the in_mux output register, one cycle behind rd_en.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         arr_valid_q <= 1'b0;
      end else begin
         arr_valid_q <= mux_rd_en;
      end
   end

`ifdef IN_MUX_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         stall_cnt_q <= 16'd0;
      end else if (start_acc) begin
         stall_cnt_q <= 16'd0;
      end else if ((state_q == S_ISSUE) && stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_in_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tb_in_mux_ctrl -- directed self-checking bench for in_mux_ctrl.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge. A scoreboard queue holds one {bitwidth, word} entry per
// expected read beat. Entries are pushed when a word handshake is seen and
// popped on each mux_rd_en.
// Cycle numbering inside a tile: cycle 0 is the cycle in which start is high.
// ---------------------------------------------------------------------------
module tb_in_mux_ctrl;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             RST;
   logic             start;
   logic [2:0]       cfg_bitwidth;
   logic [CNT_W-1:0] cfg_words;
   logic             word_valid;
   logic [31:0]      word_data;
   logic             word_ready;
   logic             stall;
   logic             mux_rd_en;
   logic [31:0]      mux_data;
   logic [2:0]       mux_bitwidth;
   logic             arr_valid;
   logic             busy;
   logic             done;
   logic             cfg_err;
   logic [15:0]      stall_cnt;

   in_mux_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .RST(RST), .start(start), .cfg_bitwidth(cfg_bitwidth),
      .cfg_words(cfg_words), .word_valid(word_valid), .word_data(word_data),
      .word_ready(word_ready), .stall(stall), .mux_rd_en(mux_rd_en),
      .mux_data(mux_data), .mux_bitwidth(mux_bitwidth), .arr_valid(arr_valid),
      .busy(busy), .done(done), .cfg_err(cfg_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard: {bitwidth, word} per expected read beat.
   logic [34:0] exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Per-tile observations.
   logic [2:0] cur_bw;
   int  cyc, rd_cnt, av_cnt, done_cnt, done_cyc, first_rd, last_rd;
   int  wr_cnt, wait_cnt, hs_cnt;
   logic prev_rd, last_hs, err_at1, busy_at1;
   logic finished, aborted;

`ifdef IN_MUX_CTRL_STALL_CNT_EN
   localparam bit STALL_CNT_ON = 1'b1;
`else
   localparam bit STALL_CNT_ON = 1'b0;
`endif

   function automatic int beats(input logic [2:0] b);
      case (b)
         3'b100:  return 4;
         3'b010:  return 2;
         3'b001:  return 1;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on the falling edge. Pop before push: in a zero-bubble cycle the
   // old word's final beat and the new word's handshake happen together.
   task automatic sample();
      logic [34:0] e;
      check("arr_valid_delay", 64'(arr_valid), 64'(prev_rd));
      if (arr_valid) av_cnt++;
      prev_rd = mux_rd_en;
      if (mux_rd_en) begin
         rd_cnt++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
         if (exp_q.size() == 0) begin
            check("rd_en_unexpected", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("mux_data", 64'(mux_data), 64'(e[31:0]));
            check("mux_bitwidth", 64'(mux_bitwidth), 64'(e[34:32]));
         end
      end
      last_hs = word_valid && word_ready;
      if (last_hs) begin
         hs_cnt++;
         for (int b = 0; b < beats(cur_bw); b++) exp_q.push_back({cur_bw, word_data});
      end
      if (word_ready) wr_cnt++;
      if (word_ready && !word_valid) wait_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (cyc == 1) begin
         err_at1  = cfg_err;
         busy_at1 = busy;
      end
      cyc++;
   endtask

   task automatic clear_obs();
      cyc = 0; rd_cnt = 0; av_cnt = 0; done_cnt = 0; done_cyc = -1;
      first_rd = -1; last_rd = -1; wr_cnt = 0; wait_cnt = 0; hs_cnt = 0;
      err_at1 = 1'bx; busy_at1 = 1'bx; finished = 1'b0; aborted = 1'b0;
   endtask

   // Runs one tile. word_valid drops for gap_len cycles after handshake number
   // gap_after. stall rises for stall_len cycles after read beat number
   // stall_after. RST is pulsed after read beat number rst_after. Use -1 to
   // disable any of these.
   task automatic run_tile(input logic [2:0] bw, input int words,
                           input int gap_after, input int gap_len,
                           input int stall_after, input int stall_len,
                           input int rst_after);
      int gap_left, stall_left;
      bit gap_done, stall_done;
      clear_obs();
      cur_bw = bw;
      gap_left = 0; stall_left = 0; gap_done = 0; stall_done = 0;
      start = 1'b1;
      cfg_bitwidth = bw;
      cfg_words = CNT_W'(words);
      word_valid = 1'b1;
      word_data = $urandom;
      stall = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         sample();
         if (done) finished = 1'b1;
         if (rst_after >= 0 && rd_cnt == rst_after) begin
            #2;
            RST = 1'b1;
            #1;
            check("outputs_zero_in_reset",
                  64'({word_ready, mux_rd_en, mux_data, mux_bitwidth, arr_valid,
                       busy, done, cfg_err, stall_cnt}), 64'(0));
            aborted = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (finished) break;
         if (last_hs) word_data = $urandom;
         if (gap_after >= 0 && hs_cnt == gap_after && !gap_done) begin
            gap_left = gap_len;
            gap_done = 1;
         end
         if (gap_left > 0) begin
            word_valid = 1'b0;
            gap_left--;
         end else begin
            word_valid = 1'b1;
         end
         if (stall_after >= 0 && rd_cnt == stall_after && !stall_done) begin
            stall_left = stall_len;
            stall_done = 1;
         end
         if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
         end else begin
            stall = 1'b0;
         end
      end
      check("tile_terminated", 64'(finished | aborted), 64'(1));
      stall = 1'b0;
      word_valid = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      start = 1'b0;
      cfg_bitwidth = 3'b000;
      cfg_words = '0;
      word_valid = 1'b0;
      word_data = 32'd0;
      stall = 1'b0;
      prev_rd = 1'b0;
      cur_bw = 3'b000;
      clear_obs();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            64'({word_ready, mux_rd_en, mux_data, mux_bitwidth, arr_valid,
                 busy, done, cfg_err, stall_cnt}), 64'(0));
      @(posedge clk);
      #1;
      RST = 1'b0;

      // 8b, 2 words, no stall: beats in cycles 2..9, DRAIN 10, DONE 11.
      run_tile(3'b100, 2, -1, 0, -1, 0, -1);
      check("t1_rd_cnt", 64'(rd_cnt), 64'(8));
      check("t1_first_rd", 64'(first_rd), 64'(2));
      check("t1_contiguous", 64'(last_rd - first_rd + 1), 64'(8));
      check("t1_arr_valid_cnt", 64'(av_cnt), 64'(8));
      check("t1_done_cnt", 64'(done_cnt), 64'(1));
      check("t1_done_cyc", 64'(done_cyc), 64'(11));
      check("t1_busy_at1", 64'(busy_at1), 64'(1));
      check("t1_stall_cnt", 64'(stall_cnt), 64'(0));
      check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

      // 4b, 3 words, valid low cycles 2..5. Ready-without-valid in cycle 3
      // (final beat) plus 2 cycles waiting in LOAD (4, 5). Done in cycle 12.
      run_tile(3'b010, 3, 1, 4, -1, 0, -1);
      check("t2_rd_cnt", 64'(rd_cnt), 64'(6));
      check("t2_wait_cnt", 64'(wait_cnt), 64'(3));
      check("t2_done_cyc", 64'(done_cyc), 64'(12));
      check("t2_done_cnt", 64'(done_cnt), 64'(1));
      check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

      // 2b, 4 words, stall for 3 cycles after the first beat.
      run_tile(3'b001, 4, -1, 0, 1, 3, -1);
      check("t3_rd_cnt", 64'(rd_cnt), 64'(4));
      check("t3_span", 64'(last_rd - first_rd + 1), 64'(7));
      check("t3_done_cyc", 64'(done_cyc), 64'(10));
      check("t3_stall_cnt", 64'(stall_cnt), 64'(STALL_CNT_ON ? 3 : 0));
      check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

      // Illegal bitwidth 011: straight to DONE with the error flag set.
      run_tile(3'b011, 4, -1, 0, -1, 0, -1);
      check("t4_rd_cnt", 64'(rd_cnt), 64'(0));
      check("t4_word_ready_cnt", 64'(wr_cnt), 64'(0));
      check("t4_done_cnt", 64'(done_cnt), 64'(1));
      check("t4_done_cyc", 64'(done_cyc), 64'(1));
      check("t4_cfg_err_at1", 64'(err_at1), 64'(1));
      check("t4_cfg_err_sticky", 64'(cfg_err), 64'(1));

      // A legal start clears cfg_err and the stall counter.
      run_tile(3'b100, 1, -1, 0, -1, 0, -1);
      check("t5_cfg_err_at1", 64'(err_at1), 64'(0));
      check("t5_cfg_err_after", 64'(cfg_err), 64'(0));
      check("t5_rd_cnt", 64'(rd_cnt), 64'(4));
      check("t5_done_cyc", 64'(done_cyc), 64'(7));
      check("t5_stall_cnt", 64'(stall_cnt), 64'(0));

      // Reset mid-tile after 6 beats: no done, then a full 20-beat tile.
      run_tile(3'b100, 5, -1, 0, -1, 0, 6);
      check("t6_aborted", 64'(aborted), 64'(1));
      @(posedge clk);
      #1;
      RST = 1'b0;
      exp_q.delete();
      prev_rd = 1'b0;
      clear_obs();
      repeat (4) begin
         @(negedge clk);
         sample();
      end
      check("t6_no_done", 64'(done_cnt), 64'(0));
      check("t6_idle_no_ready", 64'(wr_cnt), 64'(0));
      @(posedge clk);
      #1;
      run_tile(3'b100, 5, -1, 0, -1, 0, -1);
      check("t6_rd_cnt", 64'(rd_cnt), 64'(20));
      check("t6_contiguous", 64'(last_rd - first_rd + 1), 64'(20));
      check("t6_done_cyc", 64'(done_cyc), 64'(23));
      check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

      // Zero words: DONE state in the cycle after the accepted start.
      run_tile(3'b010, 0, -1, 0, -1, 0, -1);
      check("t7_rd_cnt", 64'(rd_cnt), 64'(0));
      check("t7_word_ready_cnt", 64'(wr_cnt), 64'(0));
      check("t7_done_cnt", 64'(done_cnt), 64'(1));
      check("t7_done_cyc", 64'(done_cyc), 64'(1));

      // start outside IDLE is ignored: a second start mid-tile adds no beats.
      clear_obs();
      cur_bw = 3'b001;
      start = 1'b1; cfg_bitwidth = 3'b001; cfg_words = CNT_W'(2);
      word_valid = 1'b1; word_data = $urandom;
      for (int c = 0; c < 50 && !finished; c++) begin
         @(negedge clk);
         sample();
         if (done) finished = 1'b1;
         @(posedge clk);
         #1;
         if (last_hs) word_data = $urandom;
         start = (cyc == 2);
         cfg_words = CNT_W'(7);
      end
      start = 1'b0;
      word_valid = 1'b0;
      check("t8_finished", 64'(finished), 64'(1));
      check("t8_rd_cnt", 64'(rd_cnt), 64'(2));
      check("t8_done_cnt", 64'(done_cnt), 64'(1));
      check("t8_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
